// File: rtl/xor_stream_checksum_pkg.sv
// Shared types for the framed XOR checksum engine: FSM states and the result payload.
package xor_stream_checksum_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_MAX_LEN = 16;
  localparam int unsigned DEF_CNT_W   = $clog2(DEF_MAX_LEN + 1);

  // Result payload as seen by consumers of the default configuration.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    logic [DEF_CNT_W-1:0] len;
    logic                 parity;
    logic                 err;
  } chk_result_t;

endpackage

// File: rtl/xor_stream_checksum_xor_word.sv
// WIDTH-wide bitwise XOR of two words, used for the accumulator update.
module xor_word #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_stream_checksum.sv
// Framed XOR checksum engine: accumulates words from SEED until the last beat,
// then presents sum, saturated length, parity and overflow on a valid/ready output.
module xor_stream_checksum #(
  parameter int unsigned     WIDTH   = 8,
  parameter int unsigned     MAX_LEN = 16,
  parameter logic [WIDTH-1:0] SEED   = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   out_sum,
  output logic [$clog2(MAX_LEN+1)-1:0]       out_len,
  output logic                               out_parity,
  output logic                               out_err
);

  import xor_stream_checksum_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] len;
    logic             parity;
    logic             err;
  } result_t;

  localparam result_t RES_RESET = '{sum: SEED, len: '0, parity: ^SEED, err: 1'b0};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  result_t          res_q, res_d;

  logic [WIDTH-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             err_upd;
  logic             cnt_sat;
  logic             beat_acc;

  xor_word #(.WIDTH(WIDTH)) u_acc_xor (
    .a (acc_q),
    .b (in_data),
    .y (acc_upd)
  );

  // Count saturates at MAX_LEN; any beat arriving at saturation flags overflow.
  always_comb begin
    beat_acc = in_valid && ready_q;
    cnt_sat  = (cnt_q == CNT_W'(MAX_LEN));
    cnt_upd  = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
    err_upd  = err_q | cnt_sat;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ready_d = ready_q;
    valid_d = valid_q;
    res_d   = res_q;
    case (state_q)
      ST_ACCUM: begin
        if (beat_acc) begin
          acc_d = acc_upd;
          cnt_d = cnt_upd;
          err_d = err_upd;
          if (in_last) begin
            state_d      = ST_DONE;
            ready_d      = 1'b0;
            valid_d      = 1'b1;
            res_d.sum    = acc_upd;
            res_d.len    = cnt_upd;
            res_d.parity = ^acc_upd;
            res_d.err    = err_upd;
          end
        end
      end
      ST_DONE: begin
        // Result held until taken; input reopens the cycle after the handshake.
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = SEED;
          cnt_d   = '0;
          err_d   = 1'b0;
          ready_d = 1'b1;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= SEED;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      res_q   <= RES_RESET;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign out_sum    = res_q.sum;
  assign out_len    = res_q.len;
  assign out_parity = res_q.parity;
  assign out_err    = res_q.err;

endmodule

// File: tb/tb_xor_stream_checksum.sv
// Bench for xor_stream_checksum: two instances (SEED=0/MAX_LEN=4 and SEED=FF/MAX_LEN=16)
// fed the same stream, checked against a frame-level reference model.
module tb_xor_stream_checksum;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_parity_a, out_err_a;
  logic [7:0] out_sum_a;
  logic [2:0] out_len_a;
  logic       in_ready_b, out_valid_b, out_parity_b, out_err_b;
  logic [7:0] out_sum_b;
  logic [4:0] out_len_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  beats_q[$];
  int unsigned gaps_q[$];

  xor_stream_checksum #(.WIDTH(8), .MAX_LEN(4), .SEED(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
    .out_len(out_len_a), .out_parity(out_parity_a), .out_err(out_err_a)
  );

  xor_stream_checksum #(.WIDTH(8), .MAX_LEN(16), .SEED(8'hFF)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
    .out_len(out_len_b), .out_parity(out_parity_b), .out_err(out_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed result vectors: {valid, sum, len(5b), parity, err}
  function automatic logic [15:0] obs_a();
    return {out_valid_a, out_sum_a, 5'(out_len_a), out_parity_a, out_err_a};
  endfunction

  function automatic logic [15:0] obs_b();
    return {out_valid_b, out_sum_b, out_len_b, out_parity_b, out_err_b};
  endfunction

  // Frame-level reference: XOR of seed and every beat, length clipped, error if too long.
  function automatic logic [15:0] model(input logic [7:0] seed, input int unsigned max_len);
    logic [7:0]  s;
    int unsigned n;
    int unsigned len;
    s = seed;
    n = beats_q.size();
    foreach (beats_q[i]) s = s ^ beats_q[i];
    len = (n > max_len) ? max_len : n;
    return {1'b1, s, 5'(len), ^s, (n > max_len)};
  endfunction

  task automatic drive_beat(input logic [7:0] d, input logic l);
    int budget;
    budget = 20;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready_a !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_err++;
      $display("FAIL beat_accept_timeout: in_ready=%b want 1", in_ready_a);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic send_frame();
    for (int i = 0; i < beats_q.size(); i++) begin
      repeat (gaps_q[i]) @(negedge clk);
      drive_beat(beats_q[i], i == beats_q.size() - 1);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic load(input logic [7:0] b0, input int unsigned n);
    beats_q.delete();
    gaps_q.delete();
    for (int i = 0; i < n; i++) begin
      beats_q.push_back(b0);
      gaps_q.push_back(0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs_a() !== {1'b0, 8'h00, 5'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_a: got %h want %h", obs_a(), {1'b0, 8'h00, 5'd0, 1'b0, 1'b0});
    end
    n_cmp++;
    if (obs_b() !== {1'b0, 8'hFF, 5'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_b: got %h want %h", obs_b(), {1'b0, 8'hFF, 5'd0, 1'b0, 1'b0});
    end
    n_cmp++;
    if ({in_ready_a, in_ready_b} !== 2'b11) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 11", {in_ready_a, in_ready_b});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    beats_q = '{8'h12, 8'h34, 8'h56};
    gaps_q  = '{0, 0, 0};
    send_frame();
    n_cmp++;
    if (obs_a() !== {1'b1, 8'h70, 5'd3, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL basic_a: got %h want %h", obs_a(), {1'b1, 8'h70, 5'd3, 1'b1, 1'b0});
    end
    n_cmp++;
    if (obs_b() !== {1'b1, 8'h8F, 5'd3, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL basic_b: got %h want %h", obs_b(), {1'b1, 8'h8F, 5'd3, 1'b1, 1'b0});
    end
    release_result();
    n_cmp++;
    if ({in_ready_a, out_valid_a, in_ready_b, out_valid_b} !== 4'b1010) begin
      n_err++; $display("FAIL basic_release: got %b want 1010", {in_ready_a, out_valid_a, in_ready_b, out_valid_b});
    end
  endtask

  task automatic test_single();
    load(8'hA5, 1);
    send_frame();
    n_cmp++;
    if (obs_a() !== {1'b1, 8'hA5, 5'd1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL single_a: got %h want %h", obs_a(), {1'b1, 8'hA5, 5'd1, 1'b0, 1'b0});
    end
    n_cmp++;
    if (obs_b() !== {1'b1, 8'h5A, 5'd1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL single_b: got %h want %h", obs_b(), {1'b1, 8'h5A, 5'd1, 1'b0, 1'b0});
    end
    release_result();
  endtask

  task automatic test_backpressure();
    load(8'h3C, 1);
    send_frame();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      n_cmp++;
      if (obs_a() !== {1'b1, 8'h3C, 5'd1, 1'b0, 1'b0} || in_ready_a !== 1'b0) begin
        n_err++; $display("FAIL hold_a[%0d]: got %h rdy %b want %h rdy 0", c, obs_a(), in_ready_a, {1'b1, 8'h3C, 5'd1, 1'b0, 1'b0});
      end
      n_cmp++;
      if (obs_b() !== {1'b1, 8'hC3, 5'd1, 1'b0, 1'b0} || in_ready_b !== 1'b0) begin
        n_err++; $display("FAIL hold_b[%0d]: got %h rdy %b want %h rdy 0", c, obs_b(), in_ready_b, {1'b1, 8'hC3, 5'd1, 1'b0, 1'b0});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_data   = 8'h0F;
    in_last   = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    drive_beat(8'h0F, 1'b1);
    n_cmp++;
    if (obs_a() !== {1'b1, 8'h0F, 5'd1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL bp_next_a: got %h want %h", obs_a(), {1'b1, 8'h0F, 5'd1, 1'b0, 1'b0});
    end
    n_cmp++;
    if (obs_b() !== {1'b1, 8'hF0, 5'd1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL bp_next_b: got %h want %h", obs_b(), {1'b1, 8'hF0, 5'd1, 1'b0, 1'b0});
    end
    release_result();
  endtask

  task automatic test_overflow();
    load(8'h11, 4);
    send_frame();
    n_cmp++;
    if (obs_a() !== {1'b1, 8'h00, 5'd4, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL exact_max_a: got %h want %h", obs_a(), {1'b1, 8'h00, 5'd4, 1'b0, 1'b0});
    end
    release_result();
    load(8'h01, 6);
    send_frame();
    n_cmp++;
    if (obs_a() !== {1'b1, 8'h00, 5'd4, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL overflow_a: got %h want %h", obs_a(), {1'b1, 8'h00, 5'd4, 1'b0, 1'b1});
    end
    n_cmp++;
    if (obs_b() !== {1'b1, 8'hFF, 5'd6, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL overflow_b: got %h want %h", obs_b(), {1'b1, 8'hFF, 5'd6, 1'b0, 1'b0});
    end
    release_result();
    load(8'h03, 1);
    send_frame();
    n_cmp++;
    if (obs_a() !== {1'b1, 8'h03, 5'd1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL after_ovf_a: got %h want %h", obs_a(), {1'b1, 8'h03, 5'd1, 1'b0, 1'b0});
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    drive_beat(8'hAA, 1'b0);
    drive_beat(8'h55, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_a() !== {1'b0, 8'h00, 5'd0, 1'b0, 1'b0} || in_ready_a !== 1'b1) begin
      n_err++; $display("FAIL midreset_a: got %h rdy %b want %h rdy 1", obs_a(), in_ready_a, {1'b0, 8'h00, 5'd0, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    load(8'hFF, 1);
    send_frame();
    n_cmp++;
    if (obs_a() !== {1'b1, 8'hFF, 5'd1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL post_reset_a: got %h want %h", obs_a(), {1'b1, 8'hFF, 5'd1, 1'b0, 1'b0});
    end
    n_cmp++;
    if (obs_b() !== {1'b1, 8'h00, 5'd1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL post_reset_b: got %h want %h", obs_b(), {1'b1, 8'h00, 5'd1, 1'b0, 1'b0});
    end
    // Reset while a result is pending drops it.
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_b() !== {1'b0, 8'hFF, 5'd0, 1'b0, 1'b0} || in_ready_b !== 1'b1) begin
      n_err++; $display("FAIL done_reset_b: got %h rdy %b want %h rdy 1", obs_b(), in_ready_b, {1'b0, 8'hFF, 5'd0, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bubbles();
    beats_q = '{8'h80, 8'h01, 8'h02};
    gaps_q  = '{0, 3, 2};
    send_frame();
    n_cmp++;
    if (obs_a() !== {1'b1, 8'h83, 5'd3, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL bubbles_a: got %h want %h", obs_a(), {1'b1, 8'h83, 5'd3, 1'b1, 1'b0});
    end
    n_cmp++;
    if (obs_b() !== {1'b1, 8'h7C, 5'd3, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL bubbles_b: got %h want %h", obs_b(), {1'b1, 8'h7C, 5'd3, 1'b1, 1'b0});
    end
    release_result();
  endtask

  task automatic test_random();
    logic [15:0] exp_a, exp_b;
    for (int f = 0; f < 40; f++) begin
      int unsigned n;
      int unsigned hold;
      n = $urandom_range(1, 20);
      beats_q.delete();
      gaps_q.delete();
      for (int i = 0; i < n; i++) begin
        beats_q.push_back(8'($urandom));
        gaps_q.push_back((f % 2 == 0) ? 0 : $urandom_range(0, 2));
      end
      exp_a = model(8'h00, 4);
      exp_b = model(8'hFF, 16);
      send_frame();
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
        in_valid = 1'($urandom);
        n_cmp++;
        if (obs_a() !== exp_a || in_ready_a !== 1'b0) begin
          n_err++; $display("FAIL rand_a[%0d]: got %h rdy %b want %h rdy 0", f, obs_a(), in_ready_a, exp_a);
        end
        n_cmp++;
        if (obs_b() !== exp_b || in_ready_b !== 1'b0) begin
          n_err++; $display("FAIL rand_b[%0d]: got %h rdy %b want %h rdy 0", f, obs_b(), in_ready_b, exp_b);
        end
        if (h < hold) @(negedge clk);
      end
      release_result();
      n_cmp++;
      if ({in_ready_a, out_valid_a, in_ready_b, out_valid_b} !== 4'b1010) begin
        n_err++; $display("FAIL rand_release[%0d]: got %b want 1010", f, {in_ready_a, out_valid_a, in_ready_b, out_valid_b});
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_bubbles();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
